regbank_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 32×32 register bank. It shares the bank's single write port between NUM_REQ write-back requesters (e.g. ALU and load unit) using round-robin valid/ready handshakes. It also tracks which destination registers have a write still pending, so issue logic can stall on RAW hazards. It sits between the execute/memory stages and the register bank's write_enable/write_address/write_data inputs.

---
 rtl/regbank_pkg.sv | 11 +
 rtl/regbank_wb_arbiter_rr.sv | 52 +++++
 rtl/regbank_wb_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared register-bank parameters used by the bank itself and by its
// write-back arbiter.
package regbank_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regbank_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// rotating pointer; the pointer moves past the winner on every grant.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [PTR_W-1:0] win;
   logic             found;

   always_comb begin
      int unsigned idx;
      gnt   = '0;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = (32'(ptr_q) + off) % NUM_REQ;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
            win      = PTR_W'(idx);
         end
      end
      // No grant may be visible while the block is held in reset.
      if (!rst_n) begin
         gnt   = '0;
         found = 1'b0;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter for the register bank: round-robin access to the single
// write port, a registered write stage and a pending-write scoreboard.
module regbank_wb_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = regbank_pkg::DATA_W,
   parameter int ADDR_W  = regbank_pkg::ADDR_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      resv_valid,
   input  logic [ADDR_W-1:0]         resv_addr,
   input  logic [ADDR_W-1:0]         chk_addr_1,
   input  logic [ADDR_W-1:0]         chk_addr_2,
   output logic                      chk_busy_1,
   output logic                      chk_busy_2,
   output logic                      resv_conflict,
   output logic                      write_enable,
   output logic [ADDR_W-1:0]         write_address,
   output logic [DATA_W-1:0]         write_data
);

   import regbank_pkg::*;

   localparam int NREG = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [NUM_REQ-1:0] gnt;
   logic               accept;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   logic               write_enable_q,  write_enable_d;
   logic [ADDR_W-1:0]  write_address_q, write_address_d;
   logic [DATA_W-1:0]  write_data_q,    write_data_d;
   logic [NREG-1:0]    busy_q,          busy_d;
   logic               resv_conflict_q, resv_conflict_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .gnt   (gnt)
   );

   assign req_ready = gnt;
   assign accept    = |gnt;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Writes to register 0 are consumed but never reach the bank.
   always_comb begin
      write_enable_d  = accept && (sel_addr != ZERO_ADDR);
      write_address_d = accept ? sel_addr : write_address_q;
      write_data_d    = accept ? sel_data : write_data_q;
   end

   // Reset gates the enable so an in-flight write never commits.
   assign write_enable  = write_enable_q & rst_n;
   assign write_address = write_address_q;
   assign write_data    = write_data_q;

   always_comb begin
      logic clr;
      logic set;
      busy_d = '0;
      clr    = 1'b0;
      set    = 1'b0;
      for (int unsigned r = 1; r < NREG; r++) begin
         clr       = write_enable && (write_address_q == ADDR_W'(r));
         set       = resv_valid && (resv_addr == ADDR_W'(r));
         busy_d[r] = set | (busy_q[r] & ~clr);
      end
      resv_conflict_d = resv_valid && (resv_addr != ZERO_ADDR) && busy_q[resv_addr]
                        && !(write_enable && (write_address_q == resv_addr));
   end

   assign chk_busy_1    = busy_q[chk_addr_1];
   assign chk_busy_2    = busy_q[chk_addr_2];
   assign resv_conflict = resv_conflict_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_enable_q  <= 1'b0;
         write_address_q <= '0;
         write_data_q    <= '0;
         busy_q          <= '0;
         resv_conflict_q <= 1'b0;
      end else begin
         write_enable_q  <= write_enable_d;
         write_address_q <= write_address_d;
         write_data_q    <= write_data_d;
         busy_q          <= busy_d;
         resv_conflict_q <= resv_conflict_d;
      end
   end

endmodule
